// File: rtl/ps2_keycode_rx_if.sv
// rtl/ps2_keycode_rx_if.sv - PS/2 line inputs and decoded keycode outputs of ps2_keycode_rx
interface ps2_keycode_rx_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] keycode;
  logic [7:0] scan_byte;
  logic       scan_valid;
  logic       frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  keycode, scan_byte, scan_valid, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output keycode, scan_byte, scan_valid, frame_err
  );
endinterface

// File: rtl/ps2_keycode_rx.sv
// rtl/ps2_keycode_rx.sv - PS/2 set-2 receiver and make/break decoder to HID keycodes
// Optional odd-parity enforcement: PS2_PARITY_CHECK_EN
module ps2_keycode_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic             Clk,
  input logic             Reset_n,
  ps2_keycode_rx_if.slave bus
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {D_BASE, D_EXT, D_BRK, D_EXTBRK} dec_state_e;

  rx_state_e  rx_state_q;
  dec_state_e dec_state_q;

  logic [1:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    data_sync_q, data_sync_d;
  logic          clk_filt_q, clk_filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic [TW-1:0] wdog_q, wdog_d;

  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q;
`ifdef PS2_PARITY_CHECK_EN
  logic       par_q;
`endif
  logic [7:0] scan_byte_q;
  logic       scan_valid_q;
  logic       frame_err_q;
  logic [7:0] keycode_q;

  logic       rx_bit;
  logic       fall_edge;
  logic       any_edge;
  logic       timeout;
  logic       frame_ok;
  logic [7:0] hid_base;
  logic [7:0] hid_ext;

  function automatic logic [7:0] map_base(input logic [7:0] code);
    case (code)
      8'h1C:   return 8'h04;
      8'h23:   return 8'h07;
      8'h1D:   return 8'h1A;
      8'h1B:   return 8'h16;
      8'h29:   return 8'h2C;
      8'h5A:   return 8'h28;
      8'h76:   return 8'h29;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] map_ext(input logic [7:0] code);
    case (code)
      8'h6B:   return 8'h50;
      8'h74:   return 8'h4F;
      8'h75:   return 8'h52;
      8'h72:   return 8'h51;
      default: return 8'h00;
    endcase
  endfunction

  assign rx_bit   = data_sync_q[1];
  assign hid_base = map_base(scan_byte_q);
  assign hid_ext  = map_ext(scan_byte_q);

`ifdef PS2_PARITY_CHECK_EN
  assign frame_ok = rx_bit & (^{shift_q, par_q});
`else
  assign frame_ok = rx_bit;
`endif

  // Filtered clock flips only after FILTER_LEN consecutive samples disagree with it.
  always_comb begin
    clk_sync_d  = {clk_sync_q[0], bus.ps2_clk};
    data_sync_d = {data_sync_q[0], bus.ps2_data};
    clk_filt_d  = clk_filt_q;
    filt_cnt_d  = '0;
    any_edge    = 1'b0;
    fall_edge   = 1'b0;
    if (clk_sync_q[1] != clk_filt_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        clk_filt_d = clk_sync_q[1];
        any_edge   = 1'b1;
        fall_edge  = clk_filt_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    wdog_d  = '0;
    timeout = 1'b0;
    if (rx_state_q != RX_IDLE && !any_edge) begin
      if (wdog_q == TW'(TIMEOUT_CYCLES - 1)) begin
        timeout = 1'b1;
      end else begin
        wdog_d = wdog_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_filt_q  <= 1'b1;
      filt_cnt_q  <= '0;
      wdog_q      <= '0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_filt_q  <= clk_filt_d;
      filt_cnt_q  <= filt_cnt_d;
      wdog_q      <= wdog_d;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rx_state_q   <= RX_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
`ifdef PS2_PARITY_CHECK_EN
      par_q        <= 1'b0;
`endif
      scan_byte_q  <= '0;
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (timeout) begin
        rx_state_q  <= RX_IDLE;
        frame_err_q <= 1'b1;
      end else if (fall_edge) begin
        case (rx_state_q)
          RX_IDLE: begin
            if (!rx_bit) begin
              rx_state_q <= RX_DATA;
              bit_cnt_q  <= '0;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
          RX_DATA: begin
            shift_q[bit_cnt_q] <= rx_bit;
            bit_cnt_q          <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) rx_state_q <= RX_PARITY;
          end
          RX_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            par_q      <= rx_bit;
`endif
            rx_state_q <= RX_STOP;
          end
          default: begin
            if (frame_ok) begin
              scan_byte_q  <= shift_q;
              scan_valid_q <= 1'b1;
            end else begin
              frame_err_q  <= 1'b1;
            end
            rx_state_q <= RX_IDLE;
          end
        endcase
      end
    end
  end

  // Single-key tracking: a break clears keycode only when it names the held key.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      dec_state_q <= D_BASE;
      keycode_q   <= '0;
    end else if (timeout) begin
      dec_state_q <= D_BASE;
    end else if (scan_valid_q) begin
      case (dec_state_q)
        D_BASE: begin
          if (scan_byte_q == 8'hE0) begin
            dec_state_q <= D_EXT;
          end else if (scan_byte_q == 8'hF0) begin
            dec_state_q <= D_BRK;
          end else if (hid_base != 8'h00) begin
            keycode_q <= hid_base;
          end
        end
        D_EXT: begin
          if (scan_byte_q == 8'hF0) begin
            dec_state_q <= D_EXTBRK;
          end else begin
            dec_state_q <= D_BASE;
            if (hid_ext != 8'h00) keycode_q <= hid_ext;
          end
        end
        D_BRK: begin
          dec_state_q <= D_BASE;
          if (hid_base != 8'h00 && hid_base == keycode_q) keycode_q <= 8'h00;
        end
        default: begin
          dec_state_q <= D_BASE;
          if (hid_ext != 8'h00 && hid_ext == keycode_q) keycode_q <= 8'h00;
        end
      endcase
    end
  end

  assign bus.keycode    = keycode_q;
  assign bus.scan_byte  = scan_byte_q;
  assign bus.scan_valid = scan_valid_q;
  assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_ps2_keycode_rx.sv
// tb/tb_ps2_keycode_rx.sv - self-checking bench for ps2_keycode_rx with a key-event reference model
module tb_ps2_keycode_rx;
  localparam int FL = 8;
  localparam int TO = 2000;
  localparam int HP = 30;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;

  ps2_keycode_rx_if bus ();

  ps2_keycode_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .bus    (bus)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_fail = 0;

  int sv_cnt = 0;
  int fe_cnt = 0;
  int both_cnt = 0;
  int sv_long = 0;
  logic [7:0] last_byte = 8'h00;
  logic [7:0] kc_at = 8'h00;
  logic [7:0] kc_after = 8'h00;
  bit pend = 1'b0;

  logic [7:0] exp_kc = 8'h00;

  // Key table: scan code, extended flag, HID code (0 = unmapped)
  logic [7:0] k_code [14] = '{8'h1C, 8'h23, 8'h1D, 8'h1B, 8'h29, 8'h5A, 8'h76,
                              8'h6B, 8'h74, 8'h75, 8'h72, 8'h15, 8'h74, 8'h1C};
  bit         k_ext  [14] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1};
  logic [7:0] k_hid  [14] = '{8'h04, 8'h07, 8'h1A, 8'h16, 8'h2C, 8'h28, 8'h29,
                              8'h50, 8'h4F, 8'h52, 8'h51, 8'h00, 8'h00, 8'h00};

  always @(negedge Clk) begin
    if (pend) begin
      kc_after = bus.keycode;
      pend = 1'b0;
      if (bus.scan_valid) sv_long++;
    end
    if (bus.scan_valid) begin
      sv_cnt++;
      last_byte = bus.scan_byte;
      kc_at = bus.keycode;
      pend = 1'b1;
    end
    if (bus.frame_err) begin
      fe_cnt++;
      if (bus.scan_valid) both_cnt++;
    end
  end

  task automatic send_bits(input logic [10:0] bits, input int n, input int glitch_at);
    for (int i = 0; i < n; i++) begin
      bus.ps2_data = bits[i];
      if (i == glitch_at) begin
        repeat (HP / 2) @(posedge Clk);
        bus.ps2_clk = 1'b0;
        repeat (FL - 2) @(posedge Clk);
        bus.ps2_clk = 1'b1;
        repeat (HP / 2) @(posedge Clk);
      end else begin
        repeat (HP) @(posedge Clk);
      end
      bus.ps2_clk = 1'b0;
      if (i == glitch_at) begin
        repeat (HP / 2) @(posedge Clk);
        bus.ps2_clk = 1'b1;
        repeat (FL - 2) @(posedge Clk);
        bus.ps2_clk = 1'b0;
        repeat (HP / 2) @(posedge Clk);
      end else begin
        repeat (HP) @(posedge Clk);
      end
      bus.ps2_clk = 1'b1;
    end
    bus.ps2_data = 1'b1;
    repeat (HP) @(posedge Clk);
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par);
    return {1'b1, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit bad_par, input int glitch_at);
    send_bits(make_frame(b, bad_par), 11, glitch_at);
  endtask

  task automatic send_key(input logic [7:0] code, input bit ext, input bit brk);
    if (ext) send_byte(8'hE0, 1'b0, -1);
    if (brk) send_byte(8'hF0, 1'b0, -1);
    send_byte(code, 1'b0, -1);
  endtask

  task automatic test_reset;
    bus.ps2_clk = 1'b1;
    bus.ps2_data = 1'b1;
    Reset_n = 1'b0;
    repeat (4) @(negedge Clk);
    n_cmp++; if (bus.keycode !== 8'h00) begin n_fail++; $display("FAIL reset_keycode: got %h want 00", bus.keycode); end
    n_cmp++; if (bus.scan_byte !== 8'h00) begin n_fail++; $display("FAIL reset_scan_byte: got %h want 00", bus.scan_byte); end
    n_cmp++; if (bus.scan_valid !== 1'b0) begin n_fail++; $display("FAIL reset_scan_valid: got %b want 0", bus.scan_valid); end
    n_cmp++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", bus.frame_err); end
    Reset_n = 1'b1;
    repeat (4) @(negedge Clk);
    n_cmp++; if (bus.keycode !== 8'h00) begin n_fail++; $display("FAIL post_reset_keycode: got %h want 00", bus.keycode); end
  endtask

  task automatic test_first_frame;
    int sv0, fe0;
    sv0 = sv_cnt; fe0 = fe_cnt;
    send_byte(8'h1C, 1'b0, -1);
    n_cmp++; if (sv_cnt - sv0 !== 1) begin n_fail++; $display("FAIL first_sv_count: got %0d want 1", sv_cnt - sv0); end
    n_cmp++; if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL first_fe_count: got %0d want 0", fe_cnt - fe0); end
    n_cmp++; if (last_byte !== 8'h1C) begin n_fail++; $display("FAIL first_scan_byte: got %h want 1c", last_byte); end
    n_cmp++; if (kc_at !== 8'h00) begin n_fail++; $display("FAIL first_kc_same_cycle: got %h want 00", kc_at); end
    n_cmp++; if (kc_after !== 8'h04) begin n_fail++; $display("FAIL first_kc_next_cycle: got %h want 04", kc_after); end
    n_cmp++; if (sv_long !== 0) begin n_fail++; $display("FAIL first_sv_width: got %0d long pulses want 0", sv_long); end
    exp_kc = 8'h04;
  endtask

  task automatic test_break;
    send_byte(8'hF0, 1'b0, -1);
    n_cmp++; if (bus.keycode !== 8'h04) begin n_fail++; $display("FAIL break_prefix_kc: got %h want 04", bus.keycode); end
    send_byte(8'h1C, 1'b0, -1);
    n_cmp++; if (bus.keycode !== 8'h00) begin n_fail++; $display("FAIL break_release_kc: got %h want 00", bus.keycode); end
    exp_kc = 8'h00;
  endtask

  task automatic test_extended;
    send_key(8'h74, 1'b1, 1'b0);
    n_cmp++; if (bus.keycode !== 8'h4F) begin n_fail++; $display("FAIL ext_make_kc: got %h want 4f", bus.keycode); end
    send_key(8'h74, 1'b1, 1'b1);
    n_cmp++; if (bus.keycode !== 8'h00) begin n_fail++; $display("FAIL ext_break_kc: got %h want 00", bus.keycode); end
    send_key(8'h1C, 1'b0, 1'b0);
    send_key(8'h74, 1'b0, 1'b0);
    n_cmp++; if (bus.keycode !== 8'h04) begin n_fail++; $display("FAIL ext_unprefixed_kc: got %h want 04", bus.keycode); end
    send_key(8'h1C, 1'b0, 1'b1);
    n_cmp++; if (bus.keycode !== 8'h00) begin n_fail++; $display("FAIL ext_cleanup_kc: got %h want 00", bus.keycode); end
    exp_kc = 8'h00;
  endtask

  task automatic test_parity;
    int sv0, fe0;
    sv0 = sv_cnt; fe0 = fe_cnt;
    send_byte(8'h1C, 1'b1, -1);
`ifdef PS2_PARITY_CHECK_EN
    n_cmp++; if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL parity_fe_count: got %0d want 1", fe_cnt - fe0); end
    n_cmp++; if (sv_cnt - sv0 !== 0) begin n_fail++; $display("FAIL parity_sv_count: got %0d want 0", sv_cnt - sv0); end
    n_cmp++; if (bus.keycode !== 8'h00) begin n_fail++; $display("FAIL parity_kc: got %h want 00", bus.keycode); end
`else
    n_cmp++; if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL parity_fe_count: got %0d want 0", fe_cnt - fe0); end
    n_cmp++; if (sv_cnt - sv0 !== 1) begin n_fail++; $display("FAIL parity_sv_count: got %0d want 1", sv_cnt - sv0); end
    n_cmp++; if (bus.keycode !== 8'h04) begin n_fail++; $display("FAIL parity_kc: got %h want 04", bus.keycode); end
    send_key(8'h1C, 1'b0, 1'b1);
`endif
    exp_kc = 8'h00;
  endtask

  task automatic test_idle_err;
    int sv0, fe0;
    sv0 = sv_cnt; fe0 = fe_cnt;
    send_bits(11'h7FF, 1, -1);
    n_cmp++; if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL idle_fe_count: got %0d want 1", fe_cnt - fe0); end
    n_cmp++; if (sv_cnt - sv0 !== 0) begin n_fail++; $display("FAIL idle_sv_count: got %0d want 0", sv_cnt - sv0); end
  endtask

  task automatic test_timeout;
    int sv0, fe0;
    send_byte(8'hE0, 1'b0, -1);
    sv0 = sv_cnt; fe0 = fe_cnt;
    send_bits(make_frame(8'h23, 1'b0), 5, -1);
    repeat (TO + 10) @(posedge Clk);
    n_cmp++; if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL timeout_fe_count: got %0d want 1", fe_cnt - fe0); end
    n_cmp++; if (sv_cnt - sv0 !== 0) begin n_fail++; $display("FAIL timeout_sv_count: got %0d want 0", sv_cnt - sv0); end
    send_byte(8'h23, 1'b0, -1);
    n_cmp++; if (last_byte !== 8'h23) begin n_fail++; $display("FAIL timeout_next_byte: got %h want 23", last_byte); end
    n_cmp++; if (bus.keycode !== 8'h07) begin n_fail++; $display("FAIL timeout_next_kc: got %h want 07", bus.keycode); end
    send_key(8'h23, 1'b0, 1'b1);
    n_cmp++; if (bus.keycode !== 8'h00) begin n_fail++; $display("FAIL timeout_release_kc: got %h want 00", bus.keycode); end
    exp_kc = 8'h00;
  endtask

  task automatic test_glitch;
    int sv0, fe0;
    sv0 = sv_cnt; fe0 = fe_cnt;
    send_byte(8'h1D, 1'b0, 4);
    n_cmp++; if (sv_cnt - sv0 !== 1) begin n_fail++; $display("FAIL glitch_sv_count: got %0d want 1", sv_cnt - sv0); end
    n_cmp++; if (last_byte !== 8'h1D) begin n_fail++; $display("FAIL glitch_byte: got %h want 1d", last_byte); end
    n_cmp++; if (bus.keycode !== 8'h1A) begin n_fail++; $display("FAIL glitch_kc: got %h want 1a", bus.keycode); end
    send_byte(8'hF0, 1'b0, 9);
    send_byte(8'h1D, 1'b0, 2);
    n_cmp++; if (bus.keycode !== 8'h00) begin n_fail++; $display("FAIL glitch_release_kc: got %h want 00", bus.keycode); end
    n_cmp++; if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL glitch_fe_count: got %0d want 0", fe_cnt - fe0); end
    exp_kc = 8'h00;
  endtask

  task automatic test_mid_reset;
    send_key(8'h1C, 1'b0, 1'b0);
    send_bits(make_frame(8'h23, 1'b0), 5, -1);
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    n_cmp++; if (bus.keycode !== 8'h00) begin n_fail++; $display("FAIL midrst_keycode: got %h want 00", bus.keycode); end
    n_cmp++; if (bus.scan_byte !== 8'h00) begin n_fail++; $display("FAIL midrst_scan_byte: got %h want 00", bus.scan_byte); end
    n_cmp++; if (bus.scan_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_scan_valid: got %b want 0", bus.scan_valid); end
    n_cmp++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL midrst_frame_err: got %b want 0", bus.frame_err); end
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (3) @(negedge Clk);
    send_byte(8'h1C, 1'b0, -1);
    n_cmp++; if (last_byte !== 8'h1C) begin n_fail++; $display("FAIL midrst_next_byte: got %h want 1c", last_byte); end
    n_cmp++; if (bus.keycode !== 8'h04) begin n_fail++; $display("FAIL midrst_next_kc: got %h want 04", bus.keycode); end
    send_key(8'h1C, 1'b0, 1'b1);
    exp_kc = 8'h00;
  endtask

  task automatic test_random;
    int sv0, idx, nbytes, sel;
    bit brk;
    for (int ev = 0; ev < 20; ev++) begin
      sel = int'($urandom_range(0, 3));
      idx = int'($urandom_range(0, 13));
      brk = (sel >= 2);
      if (sel == 3 && exp_kc != 8'h00) begin
        for (int k = 0; k < 14; k++) if (k_hid[k] == exp_kc) idx = k;
      end
      nbytes = 1 + int'(k_ext[idx]) + int'(brk);
      sv0 = sv_cnt;
      send_key(k_code[idx], k_ext[idx], brk);
      if (k_hid[idx] != 8'h00) begin
        if (!brk) exp_kc = k_hid[idx];
        else if (exp_kc == k_hid[idx]) exp_kc = 8'h00;
      end
      n_cmp++; if (bus.keycode !== exp_kc) begin n_fail++; $display("FAIL rand_kc ev%0d code %h ext %0d brk %0d: got %h want %h", ev, k_code[idx], k_ext[idx], brk, bus.keycode, exp_kc); end
      n_cmp++; if (sv_cnt - sv0 !== nbytes) begin n_fail++; $display("FAIL rand_sv_count ev%0d: got %0d want %0d", ev, sv_cnt - sv0, nbytes); end
      n_cmp++; if (last_byte !== k_code[idx]) begin n_fail++; $display("FAIL rand_byte ev%0d: got %h want %h", ev, last_byte, k_code[idx]); end
    end
  endtask

  task automatic test_exclusive;
    n_cmp++; if (both_cnt !== 0) begin n_fail++; $display("FAIL sv_fe_overlap: got %0d cycles want 0", both_cnt); end
    n_cmp++; if (sv_long !== 0) begin n_fail++; $display("FAIL sv_pulse_width: got %0d long pulses want 0", sv_long); end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_break();
    test_extended();
    test_parity();
    test_idle_err();
    test_timeout();
    test_glitch();
    test_mid_reset();
    test_random();
    test_exclusive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_keycode_rx.md
Name: ps2_keycode_rx

Overview:
- Receives PS/2 keyboard frames (scan code set 2) and decodes make/break sequences into an 8-bit USB-HID-style keycode.
- Output drops into the game's existing keycode input (A=0x04, D=0x07, W=0x1A, space=0x2C, ...), giving a keyboard path that bypasses the NIOS/USB host.
- Sits between the ARDUINO header pins and the jump logic and colour mapper; runs on the 50 MHz system clock.

Parameters:
- FILTER_LEN, 8: cycles ps2_clk must be stable before a level change is accepted.
- TIMEOUT_CYCLES, 100000: idle cycles mid-frame before the frame is aborted (2 ms at 50 MHz).

Ports:
- Clk  input  1  system clock, 50 MHz.
- Reset_n  input  1  asynchronous, active-low reset.
- ps2_clk  input  1  raw PS/2 clock, asynchronous to Clk.
- ps2_data  input  1  raw PS/2 data, asynchronous to Clk.
- keycode  output  8  HID code of the currently held mapped key; 0x00 when none.
- scan_byte  output  8  last correctly received raw byte.
- scan_valid  output  1  one-cycle pulse, scan_byte updated.
- frame_err  output  1  one-cycle pulse on a framing, parity or timeout error.

Behaviour:
- Reset (asynchronous, Reset_n=0):
  - keycode=0x00, scan_byte=0x00, scan_valid=0, frame_err=0.
  - Both FSMs return to their idle states. Counters clear.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchroniser.
  - ps2_clk is filtered: the filtered level changes only after FILTER_LEN consecutive equal samples.
  - A bit is sampled on a filtered falling edge, using the synchronised ps2_data value in that cycle.
- Frame FSM, states RX_IDLE -> RX_DATA -> RX_PARITY -> RX_STOP:
  - Frame format: 11 bits — start(0), 8 data bits LSB first, odd parity, stop(1).
  - RX_IDLE: on an edge with data=0, go to RX_DATA with bitcnt=0. On an edge with data=1, pulse frame_err and stay in RX_IDLE.
  - RX_DATA: shift each bit into bit[bitcnt]. After the 8th bit, go to RX_PARITY.
  - RX_PARITY: store the parity bit, go to RX_STOP.
  - RX_STOP:
    - stop=1 and parity OK: scan_byte and scan_valid=1 appear in the cycle after the stop-bit edge.
    - Otherwise: pulse frame_err and discard the byte.
    - Either way, return to RX_IDLE.
  - Timeout: a watchdog counts cycles with no filtered edge in any state except RX_IDLE. It reloads on every edge. On reaching TIMEOUT_CYCLES: abort to RX_IDLE, pulse frame_err, force the decoder to D_BASE.
  - scan_valid and frame_err are never asserted in the same cycle.
- Decoder FSM, states D_BASE, D_EXT, D_BRK, D_EXTBRK; advances only on scan_valid:
  - D_BASE: E0 -> D_EXT; F0 -> D_BRK; any other byte is a base make.
  - D_EXT: F0 -> D_EXTBRK; any other byte is an extended make, then D_BASE.
  - D_BRK: any byte is a base break, then D_BASE.
  - D_EXTBRK: any byte is an extended break, then D_BASE.
- Mapping:
  - Base: 1C->04 (A), 23->07 (D), 1D->1A (W), 1B->16 (S), 29->2C (space), 5A->28 (Enter), 76->29 (Esc).
  - Extended: 6B->50 (left), 74->4F (right), 75->52 (up), 72->51 (down).
  - Unmapped codes are ignored; keycode is unchanged.
- keycode update: registered, one cycle after the scan_valid of the completing byte.
  - Make of a mapped key: keycode = its HID code. Typematic repeats rewrite the same value.
  - Break of a mapped key whose HID code equals keycode: keycode = 0x00.
  - Break of any other key: no change. Single-key tracking: press A, press D, release D -> 0x00 even though A is still held.
- Reset mid-frame discards all partial state; the next start bit is decoded normally.

Optional Feature:
- Macro: PS2_PARITY_CHECK_EN.
- Defined: a parity mismatch (data plus parity bit has an even count of ones) discards the byte and pulses frame_err.
- Undefined: the parity bit is sampled and ignored; only the start bit, stop bit and timeout are checked.

Test Plan:
- Frame 0x1C (bits 0, 00111000, p=0, 1) at a 12.5 kHz PS/2 clock -> scan_byte=0x1C, one scan_valid pulse; keycode=0x04 one cycle later.
- Bytes F0, 1C after a held A -> keycode 0x04 -> 0x00. Intermediate F0 leaves keycode at 0x04.
- Bytes E0, 74 -> keycode=0x4F. Then E0, F0, 74 -> 0x00. Plain 74 without the prefix -> ignored.
- Frame 0x1C with parity bit 1:
  - Macro defined -> frame_err pulse, no scan_valid, keycode unchanged.
  - Macro undefined -> byte accepted.
- Send start plus 4 data bits, then hold ps2_clk high for TIMEOUT_CYCLES+10 -> exactly one frame_err pulse. The following full 0x23 frame -> keycode=0x07.
- Glitch pulses on ps2_clk of FILTER_LEN-2 cycles mid-frame -> no extra bits sampled, correct byte. Reset_n asserted mid-frame -> all outputs 0x00/0 immediately.
